// File: rtl/wavetable_access_arbiter_if.sv
// Request/response bundle between the wavetable arbiter and its two requesters.
// Signals: wr_valid/wr_addr/wr_data/wr_ready (SPI write), rd_req/rd_addr/rd_valid/rd_data (fetch).
interface wavetable_access_arbiter_if #(
   parameter int AW = 3,
   parameter int DW = 8
);
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic [DW-1:0] rd_data;

   modport master (
      output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
      input  wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
      output wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/wavetable_access_arbiter.sv
// Wavetable sample store with a single access port shared by SPI writes and oscillator reads.
// Ports: clk, rst_n (async, active-low), stream_mode (0 table / 1 FIFO ring), bus (slave
// modport: write and read handshakes), fill_level, underrun (sticky), underrun_clr.
// Optional: define WAVETABLE_ARB_LOWWATER_EN to add the registered low_water output.
module wavetable_access_arbiter #(
   parameter int DEPTH     = 8,
   parameter int AW        = 3,
   parameter int DW        = 8,
   parameter int LOW_WATER = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          stream_mode,
   input  logic                          underrun_clr,
   wavetable_access_arbiter_if.slave     bus,
   output logic [AW:0]                   fill_level,
`ifdef WAVETABLE_ARB_LOWWATER_EN
   output logic                          low_water,
`endif
   output logic                          underrun
);

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   if (DEPTH != (1 << AW) || DEPTH < 2 ||
       LOW_WATER < 0 || LOW_WATER > DEPTH) begin : g_param_err
      $error("wavetable_access_arbiter: bad DEPTH/AW/LOW_WATER");
   end

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fill;
   logic          mode_q;
   logic          run;
   logic          last_winner;
   logic          rd_valid_q;
   logic [DW-1:0] rd_data_q;

   logic          mode_edge;
   logic          full;
   logic          empty;
   logic          rd_want;
   logic          wr_want;
   logic          grant_rd;
   logic          grant_wr;
   logic [AW-1:0] wa;
   logic [AW-1:0] ra;

   // A full ring drops the write out of arbitration so the reader can drain it.
   // No grants during the cycle a mode change is seen; pointers reset then.
   always_comb begin
      mode_edge = stream_mode ^ mode_q;
      full      = mode_q & (fill == FULL);
      empty     = (fill == '0);
      rd_want   = bus.rd_req & run & ~mode_edge;
      wr_want   = bus.wr_valid & run & ~mode_edge & ~full;
      grant_rd  = rd_want & (~wr_want | (last_winner == WRITE));
      grant_wr  = wr_want & ~grant_rd;
      wa        = mode_q ? wr_ptr : bus.wr_addr;
      ra        = mode_q ? rd_ptr : bus.rd_addr;
   end

   assign bus.wr_ready = grant_wr;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign fill_level   = fill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill        <= '0;
         mode_q      <= 1'b0;
         run         <= 1'b0;
         last_winner <= WRITE;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         underrun    <= 1'b0;
      end else begin
         run        <= 1'b1;
         mode_q     <= stream_mode;
         rd_valid_q <= grant_rd;

         if (rd_want && wr_want)
            last_winner <= grant_rd ? READ : WRITE;

         if (grant_wr)
            mem[wa] <= bus.wr_data;

         // An empty stream read repeats the previous sample.
         if (grant_rd && !(mode_q && empty))
            rd_data_q <= mem[ra];

         if (mode_edge) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
         end else if (mode_q) begin
            if (grant_wr) begin
               wr_ptr <= wr_ptr + AW'(1);
               fill   <= fill + (AW+1)'(1);
            end else if (grant_rd && !empty) begin
               rd_ptr <= rd_ptr + AW'(1);
               fill   <= fill - (AW+1)'(1);
            end
         end

         // A new underrun takes precedence over a clear in the same cycle.
         underrun <= (grant_rd & mode_q & empty) |
                     (underrun & ~underrun_clr);
      end
   end

`ifdef WAVETABLE_ARB_LOWWATER_EN
   localparam logic [AW:0] LW = (AW+1)'(LOW_WATER);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) low_water <= 1'b0;
      else        low_water <= mode_q & (fill <= LW);
   end
`endif

endmodule

// File: doc/wavetable_access_arbiter.md
Name: wavetable_access_arbiter

Overview:
- Owns the 8-entry wavetable sample store and shares its single access port between two requesters: the SPI register-decode write path and the oscillator's sample-fetch read path.
- Direct mode: the store is an addressed table.
- STREAM_MODE: the store is a FIFO ring with fill tracking and underrun detection.
- Sits between `spi_rx_registers` write decode and the oscillator/phase-accumulator block.

Parameters:
- DEPTH, 8, number of sample entries (power of two, at least 2)
- AW, 3, address width, log2(DEPTH)
- DW, 8, sample width in bits
- LOW_WATER, 2, fill threshold used only when WAVETABLE_ARB_LOWWATER_EN is defined

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset. Asynchronous, active-low.
- stream_mode  in  1  control[1]. 0 = direct table, 1 = FIFO ring.
- wr_valid  in  1  write request from SPI decode. Held until accepted.
- wr_addr  in  AW  write index. Ignored in stream mode.
- wr_data  in  DW  sample to write.
- wr_ready  out  1  write accepted this cycle (wr_valid & wr_ready = transfer).
- rd_req  in  1  sample fetch request from oscillator. Held until rd_valid.
- rd_addr  in  AW  read index. Ignored in stream mode.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  DW  fetched sample.
- fill_level  out  AW+1  stream-mode occupancy, 0..DEPTH. Always 0 in direct mode.
- underrun  out  1  sticky: a stream read was attempted while empty.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (async, rst_n low):
  - all storage entries = 0, wr_ptr = rd_ptr = 0, fill_level = 0
  - rd_data = 0, rd_valid = 0, wr_ready = 0, underrun = 0
  - last_winner = WRITE, so the first conflict goes to the read.
- Single port: at most one access per cycle.
- Arbitration state last_winner ∈ {READ, WRITE}:
  - Only one of rd_req / wr_valid asserted: that requester is served.
  - Both asserted: the side that did not win the previous contested cycle is served, i.e. alternating priority. No starvation; worst-case wait is 1 cycle.
- wr_ready is combinational: asserted when a write is granted and, in stream mode, fill_level < DEPTH.
- Read: granted in cycle N; rd_valid pulses and rd_data updates in cycle N+1. rd_data holds its value between reads.
- Direct mode:
  - write stores wr_data at wr_addr
  - read returns the entry at rd_addr
  - a write and a read to the same address cannot coincide (single port)
- Stream mode write:
  - stores at wr_ptr; wr_ptr increments modulo DEPTH; fill_level increments
  - when full: wr_ready = 0 and the write stalls (the requester keeps holding); the read path is still granted
- Stream mode read:
  - if fill_level > 0: returns the entry at rd_ptr; rd_ptr increments modulo DEPTH; fill_level decrements
  - if empty: rd_valid still pulses next cycle; rd_data repeats the previous sample; pointers are unchanged; underrun is set
- Pointers wrap DEPTH-1 → 0. fill_level never exceeds DEPTH and never underflows.
- Any edge of stream_mode (registered compare) clears wr_ptr, rd_ptr and fill_level in the following cycle. Storage contents are kept. A request pending during that cycle is not granted and is served the cycle after.
- underrun_clr and a new underrun in the same cycle: set wins.
- Reset asserted mid-transaction aborts it. No rd_valid is issued for a read granted just before reset.

Optional Feature:
- Macro: WAVETABLE_ARB_LOWWATER_EN.
- When defined:
  - adds output low_water (1 bit, reset 0), registered
  - low_water = stream_mode & (fill_level ≤ LOW_WATER), updated the cycle after fill_level changes
  - intended to drive a host refill interrupt/status bit
- When undefined: the port and its logic are absent; the LOW_WATER parameter is unused.

Test Plan:
- Direct mode: write 0,36,73,109,146,182,219,255 to addresses 0..7, then read addresses 7 and 0 → rd_data 255 then 0, each rd_valid exactly 1 cycle after grant.
- Contention: hold rd_req and wr_valid together for 4 cycles → grants alternate R,W,R,W. wr_ready high in cycles 2 and 4 only; 2 rd_valid pulses total.
- Stream fill: stream_mode = 1, write 9 samples 0x10..0x18 with no reads → the first 8 are accepted with fill_level reaching 8; the 9th holds wr_ready = 0. One read returns 0x10, then the 9th write completes and fill_level returns to 8.
- Wrap-around: over 20 interleaved write/read pairs in stream mode → read order equals write order; pointers wrap past 7; fill_level stays within 0..1.
- Underrun: empty FIFO, rd_req → rd_valid with rd_data = last value (e.g. 0x18), underrun = 1. It stays set until underrun_clr, then 0. Clear and a new underrun in the same cycle → remains 1.
- Mode switch / reset: fill_level = 5, toggle stream_mode → fill_level 0 the next cycle, with a pending write granted one cycle later. Assert rst_n mid-read → no rd_valid, all outputs 0.
- With WAVETABLE_ARB_LOWWATER_EN: draining from 4 to 2 entries raises low_water one cycle after fill_level = 2.
